// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs 16-bit ADD/SUB/INC/DEC as byte passes on a shared 8-bit alu.
// The low byte runs first, then the high byte. If the low pass carried or borrowed,
// a fix-up pass adds or subtracts that carry on the high byte. One request is in
// flight at a time, with a valid/ready handshake on both the request and response sides.
module alu16_sequencer #(
    parameter int unsigned     CARRY_BIT  = 0,
    parameter bit              ALWAYS_FIX = 1'b0,
    parameter int unsigned     OP_W       = 4,
    parameter logic [OP_W-1:0] OP_ADD     = OP_W'(0),
    parameter logic [OP_W-1:0] OP_SUB     = OP_W'(1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [15:0]     req_a,
    input  logic [15:0]     req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [15:0]     rsp_result,
    output logic            rsp_carry,
    output logic            rsp_zero,
    output logic            alu_en,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [OP_W-1:0] alu_opcode,
    input  logic [7:0]      alu_out,
    input  logic [7:0]      alu_flags
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LO   = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] a_q, b_q;
    logic        sub_q;
    logic [15:0] res_q;
    logic        c_lo_q, c_hi_q, c_fix_q;
    logic        alu_c;

    assign alu_c = alu_flags[CARRY_BIT];

    // Next-state logic for the byte-pass sequencer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            ST_HI:   state_d = (c_lo_q || ALWAYS_FIX) ? ST_FIX : ST_DONE;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight request without a response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture and per-pass result/carry registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            sub_q   <= 1'b0;
            res_q   <= 16'h0000;
            c_lo_q  <= 1'b0;
            c_hi_q  <= 1'b0;
            c_fix_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_q     <= req_a;
                        // INC16/DEC16 (op[1]=1) reuse ADD/SUB with B=1; op[0] selects subtract
                        b_q     <= req_op[1] ? 16'h0001 : req_b;
                        sub_q   <= req_op[0];
                        c_fix_q <= 1'b0;
                    end
                end
                ST_LO: begin
                    res_q[7:0] <= alu_out;
                    c_lo_q     <= alu_c;
                end
                ST_HI: begin
                    res_q[15:8] <= alu_out;
                    c_hi_q      <= alu_c;
                end
                ST_FIX: begin
                    res_q[15:8] <= alu_out;
                    c_fix_q     <= alu_c;
                end
                default: ;
            endcase
        end
    end

    // Drive the alu only during the byte passes; park its inputs at zero/ADD otherwise
    always_comb begin
        alu_en     = 1'b0;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_opcode = OP_ADD;
        unique case (state_q)
            ST_LO: begin
                alu_en     = 1'b1;
                alu_a      = a_q[7:0];
                alu_b      = b_q[7:0];
                alu_opcode = sub_q ? OP_SUB : OP_ADD;
            end
            ST_HI: begin
                alu_en     = 1'b1;
                alu_a      = a_q[15:8];
                alu_b      = b_q[15:8];
                alu_opcode = sub_q ? OP_SUB : OP_ADD;
            end
            ST_FIX: begin
                alu_en     = 1'b1;
                alu_a      = res_q[15:8];
                alu_b      = {7'b0, c_lo_q};
                alu_opcode = sub_q ? OP_SUB : OP_ADD;
            end
            default: ;
        endcase
    end

    // Handshake and response outputs; zero is only asserted with a valid response
    always_comb begin
        req_ready  = (state_q == ST_IDLE) && !reset;
        rsp_valid  = (state_q == ST_DONE);
        rsp_result = res_q;
        // Only one of the high or fix-up passes can produce a carry
        rsp_carry  = c_hi_q | c_fix_q;
        rsp_zero   = (state_q == ST_DONE) && (res_q == 16'h0000);
    end

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: directed vectors for alu16_sequencer. The bench contains a behavioural
// 8-bit alu model. Two instances are built, one with the default fix-up and one with ALWAYS_FIX=1.
module tb_alu16_sequencer;

    localparam int unsigned OP_W = 4;

    typedef struct {
        bit          sel;   // 0: default instance, 1: ALWAYS_FIX instance
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
        int          lat;   // cycle on which rsp_valid is seen, counting the cycle after accept as 1
        int          en;    // cycles with alu_en high
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic req_valid = 1'b0;
    logic rsp_ready = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] req_a = 16'h0;
    logic [15:0] req_b = 16'h0;

    logic            req_ready0, rsp_valid0, rsp_carry0, rsp_zero0, alu_en0;
    logic [15:0]     rsp_result0;
    logic [7:0]      alu_a0, alu_b0, alu_out0, alu_flags0;
    logic [OP_W-1:0] alu_opcode0;
    logic            req_ready1, rsp_valid1, rsp_carry1, rsp_zero1, alu_en1;
    logic [15:0]     rsp_result1;
    logic [7:0]      alu_a1, alu_b1, alu_out1, alu_flags1;
    logic [OP_W-1:0] alu_opcode1;

    logic            f_req_ready, f_rsp_valid, f_rsp_carry, f_rsp_zero, f_alu_en;
    logic [15:0]     f_rsp_result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu16_sequencer #(.CARRY_BIT(0), .ALWAYS_FIX(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel), .req_ready(req_ready0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready && !sel),
        .rsp_result(rsp_result0), .rsp_carry(rsp_carry0), .rsp_zero(rsp_zero0),
        .alu_en(alu_en0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_opcode(alu_opcode0),
        .alu_out(alu_out0), .alu_flags(alu_flags0)
    );

    alu16_sequencer #(.CARRY_BIT(0), .ALWAYS_FIX(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel), .req_ready(req_ready1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready && sel),
        .rsp_result(rsp_result1), .rsp_carry(rsp_carry1), .rsp_zero(rsp_zero1),
        .alu_en(alu_en1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_opcode1),
        .alu_out(alu_out1), .alu_flags(alu_flags1)
    );

    // Z80-style 8-bit alu: opcode 1 subtracts (C=borrow), anything else adds
    function automatic logic [15:0] alu_model(input logic [OP_W-1:0] opc,
                                              input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = (opc == OP_W'(1)) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        return {s[7], (s[7:0] == 8'h00), 5'b0, s[8], s[7:0]};
    endfunction

    always_comb begin
        {alu_flags0, alu_out0} = alu_model(alu_opcode0, alu_a0, alu_b0);
        {alu_flags1, alu_out1} = alu_model(alu_opcode1, alu_a1, alu_b1);
    end

    assign f_req_ready  = sel ? req_ready1  : req_ready0;
    assign f_rsp_valid  = sel ? rsp_valid1  : rsp_valid0;
    assign f_rsp_carry  = sel ? rsp_carry1  : rsp_carry0;
    assign f_rsp_zero   = sel ? rsp_zero1   : rsp_zero0;
    assign f_alu_en     = sel ? alu_en1     : alu_en0;
    assign f_rsp_result = sel ? rsp_result1 : rsp_result0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept one request, time the response, check it and complete the handshake
    task automatic do_op(input vec_t v);
        int n;
        int en;
        sel = v.sel;
        n = 0;
        while (!f_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", f_req_ready, 1);
        req_op = v.op; req_a = v.a; req_b = v.b; req_valid = 1'b1;
        @(posedge clk); #1;
        // Busy-time request changes must not disturb the operation
        req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 2'd1;
        n = 1;
        en = 0;
        while (!f_rsp_valid && n < 20) begin
            if (f_alu_en) en++;
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, v.lat);
        check("alu_en_cycles", en, v.en);
        check("result", f_rsp_result, v.res);
        check("carry", f_rsp_carry, v.c);
        check("zero", f_rsp_zero, v.z);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", f_rsp_valid, 0);
        check("req_ready_after_hs", f_req_ready, 1);
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        //          sel  op     a         b         res       c     z     lat en
        vecs.push_back('{1'b0, 2'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 3, 2});
        vecs.push_back('{1'b0, 2'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 4, 3});
        vecs.push_back('{1'b0, 2'd2, 16'hFFFF, 16'h5555, 16'h0000, 1'b1, 1'b1, 4, 3});
        vecs.push_back('{1'b0, 2'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 4, 3});
        vecs.push_back('{1'b0, 2'd3, 16'h0100, 16'hABCD, 16'h00FF, 1'b0, 1'b0, 4, 3});
        vecs.push_back('{1'b0, 2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 3, 2});
        vecs.push_back('{1'b0, 2'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 3, 2});
        vecs.push_back('{1'b1, 2'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 4, 3});
        vecs.push_back('{1'b1, 2'd1, 16'h5000, 16'h1000, 16'h4000, 1'b0, 1'b0, 4, 3});

        // Reset state while reset is held
        #12;
        check("rst_req_ready", req_ready0, 0);
        check("rst_rsp_valid", rsp_valid0, 0);
        check("rst_result", rsp_result0, 0);
        check("rst_carry", rsp_carry0, 0);
        check("rst_zero", rsp_zero0, 0);
        check("rst_alu_en", alu_en0, 0);
        check("rst_alu_a", alu_a0, 0);
        check("rst_alu_b", alu_b0, 0);
        check("rst_alu_opcode", alu_opcode0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("req_ready_after_release", req_ready0, 1);
        @(posedge clk); #1;

        foreach (vecs[i]) do_op(vecs[i]);

        // Held-off response: SUB16 0x1234-0x0235 = 0x0FFF, must stay stable while stalled
        sel = 1'b0;
        req_op = 2'd1; req_a = 16'h1234; req_b = 16'h0235; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("stall_rsp_valid", rsp_valid0, 1);
            check("stall_result", rsp_result0, 16'h0FFF);
            check("stall_req_ready", req_ready0, 0);
            check("stall_alu_en", alu_en0, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stall_release_idle", req_ready0, 1);

        // Reset during the HI pass discards the request
        req_op = 2'd0; req_a = 16'h1234; req_b = 16'h1111; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("hi_pass_alu_a", alu_a0, 8'h12);
        reset = 1'b1;
        #1;
        check("midrst_alu_en", alu_en0, 0);
        check("midrst_alu_a", alu_a0, 0);
        check("midrst_req_ready", req_ready0, 0);
        check("midrst_rsp_valid", rsp_valid0, 0);
        check("midrst_result", rsp_result0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_no_response", rsp_valid0, 0);
        do_op('{1'b0, 2'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 3, 2});

        // ALWAYS_FIX instance: the fix-up pass runs with b=0 on the high byte
        sel = 1'b1;
        req_op = 2'd0; req_a = 16'h1234; req_b = 16'h1111; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("fix_alu_en", alu_en1, 1);
        check("fix_alu_b", alu_b1, 8'h00);
        check("fix_alu_a", alu_a1, 8'h23);
        @(posedge clk); #1;
        check("fix_rsp_valid", rsp_valid1, 1);
        check("fix_result", rsp_result1, 16'h2345);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("fix_idle", req_ready1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
